// File: rtl/alu_seq_if.sv
// Bundle of the producer, ALU and consumer signals around alu_seq.
// ALU_SEQ_TAG_EN adds the in_tag/out_tag pair.
interface alu_seq_if #(
  parameter int N      = 8,
  parameter int CDEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N-1:0]              in_a;
  logic [N-1:0]              in_b;
  logic [3:0]                in_s;
  logic [N-1:0]              alu_a;
  logic [N-1:0]              alu_b;
  logic [3:0]                alu_s;
  logic [N-1:0]              alu_f;
  logic [5:0]                alu_flags;
  logic                      out_valid;
  logic                      out_ready;
  logic [N-1:0]              out_f;
  logic [5:0]                out_flags;
  logic [3:0]                out_s;
  logic [$clog2(CDEPTH):0]   cmd_count;

`ifdef ALU_SEQ_TAG_EN
  logic [3:0]                in_tag;
  logic [3:0]                out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_s, in_tag,
    input  alu_f, alu_flags, out_ready,
    output in_ready, alu_a, alu_b, alu_s,
    output out_valid, out_f, out_flags, out_s,
    output out_tag, cmd_count
  );

  modport master (
    output in_valid, in_a, in_b, in_s, in_tag,
    output alu_f, alu_flags, out_ready,
    input  in_ready, alu_a, alu_b, alu_s,
    input  out_valid, out_f, out_flags, out_s,
    input  out_tag, cmd_count
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_s,
    input  alu_f, alu_flags, out_ready,
    output in_ready, alu_a, alu_b, alu_s,
    output out_valid, out_f, out_flags, out_s,
    output cmd_count
  );

  modport master (
    output in_valid, in_a, in_b, in_s,
    output alu_f, alu_flags, out_ready,
    input  in_ready, alu_a, alu_b, alu_s,
    input  out_valid, out_f, out_flags, out_s,
    input  cmd_count
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Command sequencer feeding the 8-bit ALU and re-aligning flags with F.
// Optional ALU_SEQ_TAG_EN carries a 4-bit tag from in_tag to out_tag.
module alu_seq #(
  parameter int N      = 8,
  parameter int CDEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int CAW = $clog2(CDEPTH);
  localparam int RAW = $clog2(RDEPTH);

  logic [N-1:0]   ca_mem [CDEPTH];
  logic [N-1:0]   cb_mem [CDEPTH];
  logic [3:0]     cs_mem [CDEPTH];
  logic [CAW-1:0] cwr_q, cwr_d;
  logic [CAW-1:0] crd_q, crd_d;
  logic [CAW:0]   ccnt_q, ccnt_d;

  logic [N-1:0]   a_q, b_q;
  logic [3:0]     s_q;
  logic           s1_vld_q;

  logic [5:0]     fl2_q;
  logic [3:0]     s2_q;
  logic           s2_vld_q;

  logic [N-1:0]   rf_mem  [RDEPTH];
  logic [5:0]     rfl_mem [RDEPTH];
  logic [3:0]     rs_mem  [RDEPTH];
  logic [RAW-1:0] rwr_q, rwr_d;
  logic [RAW-1:0] rrd_q, rrd_d;
  logic [RAW:0]   rcnt_q, rcnt_d;

  logic           push;
  logic           issue;
  logic           rd_pop;
  logic           credit_ok;
  logic [RAW+1:0] inflight;

`ifdef ALU_SEQ_TAG_EN
  logic [3:0]     ct_mem [CDEPTH];
  logic [3:0]     rt_mem [RDEPTH];
  logic [3:0]     t1_q;
  logic [3:0]     t2_q;
`endif

  assign bus.in_ready  = (ccnt_q != (CAW+1)'(CDEPTH));
  assign push          = bus.in_valid && bus.in_ready;

  // Every issued command owns a result slot until it is read out.
  assign inflight  = (RAW+2)'(rcnt_q)
                   + (RAW+2)'(s1_vld_q)
                   + (RAW+2)'(s2_vld_q);
  assign credit_ok = (inflight < (RAW+2)'(RDEPTH));
  assign issue     = (ccnt_q != '0) && credit_ok;

  assign bus.out_valid = (rcnt_q != '0);
  assign rd_pop        = bus.out_valid && bus.out_ready;

  always_comb begin
    cwr_d  = cwr_q;
    crd_d  = crd_q;
    ccnt_d = ccnt_q;
    if (push) begin
      cwr_d = cwr_q + CAW'(1);
    end
    if (issue) begin
      crd_d = crd_q + CAW'(1);
    end
    if (push && !issue) begin
      ccnt_d = ccnt_q + (CAW+1)'(1);
    end else if (!push && issue) begin
      ccnt_d = ccnt_q - (CAW+1)'(1);
    end
  end

  always_comb begin
    rwr_d  = rwr_q;
    rrd_d  = rrd_q;
    rcnt_d = rcnt_q;
    if (s2_vld_q) begin
      rwr_d = rwr_q + RAW'(1);
    end
    if (rd_pop) begin
      rrd_d = rrd_q + RAW'(1);
    end
    if (s2_vld_q && !rd_pop) begin
      rcnt_d = rcnt_q + (RAW+1)'(1);
    end else if (!s2_vld_q && rd_pop) begin
      rcnt_d = rcnt_q - (RAW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cwr_q  <= '0;
      crd_q  <= '0;
      ccnt_q <= '0;
      rwr_q  <= '0;
      rrd_q  <= '0;
      rcnt_q <= '0;
    end else begin
      cwr_q  <= cwr_d;
      crd_q  <= crd_d;
      ccnt_q <= ccnt_d;
      rwr_q  <= rwr_d;
      rrd_q  <= rrd_d;
      rcnt_q <= rcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ca_mem[cwr_q] <= bus.in_a;
      cb_mem[cwr_q] <= bus.in_b;
      cs_mem[cwr_q] <= bus.in_s;
`ifdef ALU_SEQ_TAG_EN
      ct_mem[cwr_q] <= bus.in_tag;
`endif
    end
  end

  // Operands hold their last value when nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      s1_vld_q <= 1'b0;
`ifdef ALU_SEQ_TAG_EN
      t1_q     <= '0;
`endif
    end else begin
      s1_vld_q <= issue;
      if (issue) begin
        a_q  <= ca_mem[crd_q];
        b_q  <= cb_mem[crd_q];
        s_q  <= cs_mem[crd_q];
`ifdef ALU_SEQ_TAG_EN
        t1_q <= ct_mem[crd_q];
`endif
      end
    end
  end

  // Flags are combinational on the issued operands; F lands one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl2_q    <= '0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
`ifdef ALU_SEQ_TAG_EN
      t2_q     <= '0;
`endif
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        fl2_q <= bus.alu_flags;
        s2_q  <= s_q;
`ifdef ALU_SEQ_TAG_EN
        t2_q  <= t1_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_vld_q) begin
      rf_mem[rwr_q]  <= bus.alu_f;
      rfl_mem[rwr_q] <= fl2_q;
      rs_mem[rwr_q]  <= s2_q;
`ifdef ALU_SEQ_TAG_EN
      rt_mem[rwr_q]  <= t2_q;
`endif
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_s     = s_q;
  assign bus.cmd_count = ccnt_q;

  assign bus.out_f     = bus.out_valid ? rf_mem[rrd_q]  : '0;
  assign bus.out_flags = bus.out_valid ? rfl_mem[rrd_q] : '0;
  assign bus.out_s     = bus.out_valid ? rs_mem[rrd_q]  : '0;
`ifdef ALU_SEQ_TAG_EN
  assign bus.out_tag   = bus.out_valid ? rt_mem[rrd_q]  : '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an XOR ALU stub.
// Tag checks are active when ALU_SEQ_TAG_EN is defined.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [7:0] f;
    logic [5:0] fl;
    logic [3:0] s;
    logic [3:0] t;
    int         cyc;
  } rec_t;

  rec_t got[$];

  alu_seq_if #(.N(8), .CDEPTH(4)) bus ();

  alu_seq #(
    .N(8), .CDEPTH(4), .RDEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk) bus.alu_f <= bus.alu_a ^ bus.alu_b;

  always_comb begin
    bus.alu_flags = {
      ($signed(bus.alu_a) > $signed(bus.alu_b)),
      (bus.alu_a == bus.alu_b),
      ($signed(bus.alu_a) < $signed(bus.alu_b)),
      ((bus.alu_a ^ bus.alu_b) == 8'h00),
      2'b00
    };
  end

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      rec_t r;
      r.f   = bus.out_f;
      r.fl  = bus.out_flags;
      r.s   = bus.out_s;
`ifdef ALU_SEQ_TAG_EN
      r.t   = bus.out_tag;
`else
      r.t   = 4'h0;
`endif
      r.cyc = cyc;
      got.push_back(r);
    end
  end

  task automatic push_cmd(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic [3:0] t,
    output int         k
  );
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_s     = s;
`ifdef ALU_SEQ_TAG_EN
    bus.in_tag   = t;
`endif
    k = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k = cyc;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (k < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready never seen for a=%h t=%h", a, t);
    end
  endtask

  task automatic test_reset();
    int seen;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.cmd_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_cmd_count: got %0d want 0", bus.cmd_count);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_alu_ops: got %h %h %h want 0",
               bus.alu_a, bus.alu_b, bus.alu_s);
    end
    n_checks++;
    if ({bus.out_f, bus.out_flags, bus.out_s} !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_out_data: got %h %b %h want 0",
               bus.out_f, bus.out_flags, bus.out_s);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill the pipe with out_ready low, then reset mid-stream.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h11;
    bus.in_b      = 8'h22;
    bus.in_s      = 4'h7;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.cmd_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_cmd_count: got %0d want 0", bus.cmd_count);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.alu_a !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_alu_a: got %h want 00", bus.alu_a);
    end
    got.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0 || got.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_stale: got %0d valid cycles want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int k;
    int first;
    got.delete();
    bus.out_ready = 1'b1;
    push_cmd(8'h0F, 8'h01, 4'h3, 4'h0, k);
    first = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        first = cyc;
        break;
      end
    end
    n_checks++;
    if (first !== k + 3) begin
      n_fail++;
      $display("FAIL single_latency: got edge %0d want %0d", first, k + 3);
    end
    n_checks++;
    if (bus.out_f !== 8'h0E) begin
      n_fail++;
      $display("FAIL single_f: got %h want 0e", bus.out_f);
    end
    n_checks++;
    if (bus.out_flags !== 6'b100000) begin
      n_fail++;
      $display("FAIL single_flags: got %b want 100000", bus.out_flags);
    end
    n_checks++;
    if (bus.out_s !== 4'h3) begin
      n_fail++;
      $display("FAIL single_s: got %h want 3", bus.out_s);
    end
    repeat (3) @(posedge clk);
    #1;
    got.delete();
  endtask

  task automatic test_back_to_back();
    int         k;
    logic [5:0] exp_fl;
    got.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(8'(i), 8'h05, 4'(i), 4'(i), k);
    end
    for (int n = 0; n < 30 && got.size() < 8; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (got.size() !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      exp_fl = (i < 5)  ? 6'b001000 :
               (i == 5) ? 6'b010100 : 6'b100000;
      n_checks++;
      if (got[i].f !== (8'(i) ^ 8'h05)) begin
        n_fail++;
        $display("FAIL b2b_f[%0d]: got %h want %h", i, got[i].f,
                 8'(i) ^ 8'h05);
      end
      n_checks++;
      if (got[i].fl !== exp_fl || got[i].s !== 4'(i)) begin
        n_fail++;
        $display("FAIL b2b_fl_s[%0d]: got %b/%h want %b/%h", i,
                 got[i].fl, got[i].s, exp_fl, 4'(i));
      end
`ifdef ALU_SEQ_TAG_EN
      n_checks++;
      if (got[i].t !== 4'(i)) begin
        n_fail++;
        $display("FAIL b2b_tag[%0d]: got %h want %h", i, got[i].t, 4'(i));
      end
`endif
      if (i > 0) begin
        n_checks++;
        if (got[i].cyc !== got[i-1].cyc + 1) begin
          n_fail++;
          $display("FAIL b2b_rate[%0d]: gap %0d want 1", i,
                   got[i].cyc - got[i-1].cyc);
        end
      end
    end
    got.delete();
  endtask

  task automatic test_backpressure();
    got.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        int kk;
        for (int j = 0; j < 10; j++) begin
          push_cmd(8'(16 + j), 8'h3C, 4'(j), 4'(j), kk);
        end
      end
    join_none
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b want cnt=4 rdy=0",
               bus.cmd_count, bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || got.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b popped=%0d want 1/0",
               bus.out_valid, got.size());
    end

    // One result pop frees one credit: issue pops while the push is refused.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.cmd_count !== 3'd4) begin
      n_fail++;
      $display("FAIL bnd_refuse: got rdy=%b cnt=%0d want 0/4",
               bus.in_ready, bus.cmd_count);
    end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_count !== 3'd3 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd_popped: got cnt=%0d rdy=%b want 3/1",
               bus.cmd_count, bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_count !== 3'd4 || got.size() !== 1) begin
      n_fail++;
      $display("FAIL bnd_accept: got cnt=%0d popped=%0d want 4/1",
               bus.cmd_count, got.size());
    end

    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 60 && got.size() < 10; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (got.size() !== 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 10", got.size());
    end
    for (int j = 0; j < 10 && j < got.size(); j++) begin
      n_checks++;
      if (got[j].f !== (8'(16 + j) ^ 8'h3C) || got[j].s !== 4'(j)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h/%h want %h/%h", j,
                 got[j].f, got[j].s, 8'(16 + j) ^ 8'h3C, 4'(j));
      end
    end
    n_checks++;
    if (bus.cmd_count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got cnt=%0d valid=%b want 0/0",
               bus.cmd_count, bus.out_valid);
    end
    got.delete();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_s      = '0;
`ifdef ALU_SEQ_TAG_EN
    bus.in_tag    = '0;
`endif
    bus.out_ready = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer placed directly upstream of the 8-bit ALU top level. It buffers operand/opcode commands from a valid/ready producer and issues them one per cycle to the ALU operand ports. It re-aligns the ALU's combinational flags with its one-cycle registered result F. Result+flag records go into an output FIFO with valid/ready back-pressure, so the free-running ALU result register never needs to stall.

## Interface
- N, 8, operand/result width
- CDEPTH, 4, command FIFO depth (power of 2, ≥2)
- RDEPTH, 4, result FIFO depth (power of 2, ≥4 for full throughput)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  command FIFO can accept
- in_a, in_b  in  N  signed operands
- in_s  in  4  ALU opcode
- alu_a, alu_b  out  N  operands driven to ALU (registered)
- alu_s  out  4  opcode driven to ALU (registered)
- alu_f  in  N  ALU registered result
- alu_flags  in  6  ALU combinational flags {G,E,L,Zero,carryOut,Overflow}, MSB=G
- out_valid  out  1  result FIFO non-empty
- out_ready  in  1  consumer accepts
- out_f  out  N  result of head record
- out_flags  out  6  flags of head record
- out_s  out  4  opcode echo of head record
- cmd_count  out  $clog2(CDEPTH)+1  command FIFO occupancy

## Operation
- Push when in_valid&&in_ready. in_ready = (cmd_count != CDEPTH); it is not raised by a same-cycle pop.
- Pipeline: command FIFO → S1 (issue reg = alu_a/b/s, s1_vld) → S2 (flags + opcode hold, s2_vld) → result FIFO.
- Issue condition: command FIFO non-empty && (res_count + s1_vld + s2_vld) < RDEPTH. On issue, pop head into S1 and set s1_vld. Otherwise clear s1_vld; alu_a/b/s hold their last values.
- S1→S2 every edge, unconditionally: s2_vld<=s1_vld. When s1_vld, capture alu_flags and alu_s into S2 during the issue cycle.
- S2→result FIFO every edge when s2_vld: write {alu_f, S2 flags, S2 opcode}. alu_f is sampled in the cycle after issue.
- Credit rule guarantees the result FIFO never overflows; no S1/S2 stall exists.
- Pop the result FIFO when out_valid&&out_ready. out_* show the head combinationally (show-ahead).
- Simultaneous result write and read on a full result FIFO is legal; occupancy is unchanged.
- Commands complete strictly in order.

## Timing
- Reset (rst low, async): FIFOs empty, s1_vld=s2_vld=0, alu_a=alu_b=0, alu_s=0, out_valid=0, out_f/out_flags/out_s=0, cmd_count=0, in_ready=1.
- Deassertion of reset is taken synchronously to clk.
- Reset mid-operation discards all queued and in-flight commands. The ALU's F is ignored until a new issue.
- Latency: command accepted at edge k → issued at edge k+1 → flags captured at k+2 → result written at k+3 → out_valid high in cycle after k+3. Minimum is 3 edges.
- Throughput is 1 command/cycle with out_ready held high and RDEPTH≥4.
- With out_ready low, at most RDEPTH results are produced. After that, issue stops and the command FIFO fills.

## Configuration
- ALU_SEQ_TAG_EN defined: adds in_tag (in, 4) and out_tag (out, 4). The tag travels with the command through FIFO, S1, S2 and the result FIFO. out_tag resets to 0.
- ALU_SEQ_TAG_EN undefined: tag ports and storage are absent; all other behaviour is identical.

## Test plan
Bench uses an ALU stub with registered F<=A^B and combinational flags {A>B, A==B, A<B, (A^B)==0, 0, 0}.
- Reset: hold rst low 3 cycles mid-stream → out_valid=0, cmd_count=0, in_ready=1, alu_a=0 immediately; no stale result after release.
- Single command A=8'h0F, B=8'h01, s=4'h3 accepted at edge k → out_valid first high after edge k+3 with out_f=8'h0E, out_flags=6'b100000, out_s=4'h3.
- Back-to-back 8 commands with A=i, B=8'h05, out_ready=1 → one result per cycle, in order, out_f=i^5. Case i=5 gives out_flags=6'b010100.
- Back-pressure: out_ready=0, push 10 commands → exactly RDEPTH results buffered and cmd_count=CDEPTH, in_ready=0. Raise out_ready → all 10 drain in order with no loss or duplicate.
- Full boundary: command FIFO full, in_valid=1 while an issue pops the head → push refused that cycle and accepted the next.
- With ALU_SEQ_TAG_EN: tags 0..7 on the burst above → out_tag matches per result in order.
